// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART peripheral.
//   word_len_e    - data word length selection (5/6/7/8 bits)
//   tx_state_e    - transmitter FSM state encoding
//   word_len_bits - word length enum to number of data bits (5..8)
//   parity_bit    - transmitted parity bit from accumulator / stick control
package uart_pkg;

  typedef enum logic [1:0] {
    WORD_LEN_5 = 2'b00,
    WORD_LEN_6 = 2'b01,
    WORD_LEN_7 = 2'b10,
    WORD_LEN_8 = 2'b11
  } word_len_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP_1 = 3'd4,
    STOP_2 = 3'd5
  } tx_state_e;

  function automatic logic [3:0] word_len_bits(input word_len_e wl);
    logic [3:0] bits;
    case (wl)
      WORD_LEN_5: bits = 4'd5;
      WORD_LEN_6: bits = 4'd6;
      WORD_LEN_7: bits = 4'd7;
      WORD_LEN_8: bits = 4'd8;
      default:    bits = 4'd8;
    endcase
    return bits;
  endfunction

  // Stick parity drives the inverse of the even-select; otherwise the
  // accumulator (seeded with ~even and XORed with every data bit) is sent.
  function automatic logic parity_bit(input logic acc, input logic force_par,
                                      input logic even_par);
    logic p;
    if (force_par) begin
      p = ~even_par;
    end else begin
      p = acc;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO for the UART transmit path.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write request; accepted only when count < DEPTH
//   pop         - read request; accepted only when not empty
//   flush       - clears pointers and count; a same-cycle push/pop is dropped
//   wr_data     - data written on an accepted push
//   rd_data     - head entry (valid when empty = 0)
//   count       - entries held, 0..DEPTH
//   full, empty - status derived from the registered count
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Full is judged on the registered count, so a pop never frees room for a same-cycle push.
  assign push_ok_s = push & (count_r < DEPTH_C) & ~flush;
  assign pop_ok_s  = pop & (count_r != {CW{1'b0}}) & ~flush;

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = (count_r == DEPTH_C);
  assign empty   = (count_r == {CW{1'b0}});

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered UART transmitter (THR -> tx pin).
// Build option: define UART_TX_FIFO_EN for a DEPTH-entry transmit FIFO;
// without it a single holding register is used (fifo_count is 0 or 1).
//   clk, rst_n        - clock, asynchronous active-low reset
//   div_clk_en        - oversample tick; OVERSAMPLE ticks per bit
//   wr_valid/wr_ready - push handshake, wr_data byte (LSB first on the line)
//   flush             - discard buffered bytes (current frame still completes)
//   cfg_word_len, cfg_stop_bit, cfg_parity_en, cfg_even_parity,
//   cfg_force_parity, cfg_set_break - line configuration
//   tx                - serial output
//   fifo_count, thr_empty, tx_empty - 16550-style status
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   div_clk_en,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [7:0]             wr_data,
  input  logic                   flush,
  input  word_len_e              cfg_word_len,
  input  logic                   cfg_stop_bit,
  input  logic                   cfg_parity_en,
  input  logic                   cfg_even_parity,
  input  logic                   cfg_force_parity,
  input  logic                   cfg_set_break,
  output logic                   tx,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   thr_empty,
  output logic                   tx_empty
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST      = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);

  tx_state_e      state_r;
  logic [7:0]     shift_r;
  logic [2:0]     bit_cnt_r;
  logic [OSW-1:0] os_cnt_r;
  logic           parity_r;

  logic [7:0]     head_data_s;
  logic           empty_s;
  logic           pop_s;
  logic           bit_end_s;
  logic [OSW-1:0] os_last_s;
  logic           tx_s;

  // A byte leaves the buffer only when the FSM is ready to frame it.
  assign pop_s = (state_r == IDLE) & ~empty_s & ~flush;

`ifdef UART_TX_FIFO_EN
  logic full_s;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_valid),
    .pop     (pop_s),
    .flush   (flush),
    .wr_data (wr_data),
    .rd_data (head_data_s),
    .count   (fifo_count),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign wr_ready = ~full_s;
`else
  logic [7:0] hold_data_r;
  logic       hold_valid_r;

  // Single holding register: loads when empty, empties on pop or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_r  <= 8'h00;
      hold_valid_r <= 1'b0;
    end else if (flush) begin
      hold_valid_r <= 1'b0;
    end else if (wr_valid & ~hold_valid_r) begin
      hold_data_r  <= wr_data;
      hold_valid_r <= 1'b1;
    end else if (pop_s) begin
      hold_valid_r <= 1'b0;
    end
  end

  assign wr_ready    = ~hold_valid_r;
  assign empty_s     = ~hold_valid_r;
  assign head_data_s = hold_data_r;
  assign fifo_count  = {{(CW-1){1'b0}}, hold_valid_r};
`endif

  // Last tick index of the current bit: half a bit for the 1.5-stop case.
  always_comb begin
    os_last_s = OS_LAST;
    if ((state_r == STOP_2) && (cfg_word_len == WORD_LEN_5)) begin
      os_last_s = OS_HALF_LAST;
    end else begin
      os_last_s = OS_LAST;
    end
  end

  // Bit boundary strobe: the tick that completes the current bit.
  always_comb begin
    bit_end_s = 1'b0;
    if ((state_r != IDLE) && div_clk_en) begin
      bit_end_s = (os_cnt_r == os_last_s);
    end else begin
      bit_end_s = 1'b0;
    end
  end

  // Transmit FSM with its datapath (shift register, counters, parity).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      os_cnt_r  <= {OSW{1'b0}};
      parity_r  <= 1'b0;
    end else begin
      if ((state_r != IDLE) && div_clk_en) begin
        os_cnt_r <= bit_end_s ? {OSW{1'b0}} : (os_cnt_r + 1'b1);
      end
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r   <= START;
            shift_r   <= head_data_s;
            parity_r  <= ~cfg_even_parity;
            bit_cnt_r <= 3'd0;
            os_cnt_r  <= {OSW{1'b0}};
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r <= DATA;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            parity_r <= parity_r ^ shift_r[0];
            shift_r  <= {1'b0, shift_r[7:1]};
            if ({1'b0, bit_cnt_r} == (word_len_bits(cfg_word_len) - 4'd1)) begin
              bit_cnt_r <= 3'd0;
              state_r   <= cfg_parity_en ? PARITY : STOP_1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            state_r <= STOP_1;
          end
        end
        STOP_1: begin
          if (bit_end_s) begin
            state_r <= cfg_stop_bit ? STOP_2 : IDLE;
          end
        end
        STOP_2: begin
          if (bit_end_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Line level from registered state; break overrides without stalling the FSM.
  always_comb begin
    tx_s = 1'b1;
    if (cfg_set_break) begin
      tx_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    tx_s = 1'b1;
        START:   tx_s = 1'b0;
        DATA:    tx_s = shift_r[0];
        PARITY:  tx_s = parity_bit(parity_r, cfg_force_parity, cfg_even_parity);
        STOP_1:  tx_s = 1'b1;
        STOP_2:  tx_s = 1'b1;
        default: tx_s = 1'b1;
      endcase
    end
  end

  assign tx        = tx_s;
  assign thr_empty = empty_s;
  assign tx_empty  = empty_s & (state_r == IDLE);

endmodule
